// File: rtl/mul_pipe_ctrl.sv
// Sequencing controller for the pipelined Booth/Wallace multiplier datapath.
// Tracks valid/op/tag per datapath stage, drives stage capture enables with a
// backpressure chain, extends operands, and selects the returned product half.
module mul_pipe_ctrl #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned STAGES = 2,
   parameter int unsigned TAG_W  = 5
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0]            in_op,
   input  logic [DATA_W-1:0]     in_a,
   input  logic [DATA_W-1:0]     in_b,
   input  logic [TAG_W-1:0]      in_dest,
   input  logic                  flush,
   output logic [DATA_W:0]       dp_a,
   output logic [DATA_W:0]       dp_b,
   output logic [STAGES-1:0]     dp_en,
   input  logic [2*DATA_W-1:0]   dp_prod,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     out_result,
   output logic [TAG_W-1:0]      out_dest,
   output logic                  busy,
   output logic [31:0]           done_cnt,
   output logic [31:0]           stall_cnt
);

   localparam int unsigned Last = STAGES - 1;

   localparam logic [1:0] OpMul   = 2'b00;
   localparam logic [1:0] OpMulh  = 2'b01;
   localparam logic [1:0] OpMulhu = 2'b10;

   logic [STAGES-1:0]            v_q, v_d;
   logic [STAGES-1:0][1:0]       op_q, op_d;
   logic [STAGES-1:0][TAG_W-1:0] dest_q, dest_d;
   logic [31:0]                  done_cnt_q, done_cnt_d;
   logic [31:0]                  stall_cnt_q, stall_cnt_d;

   logic [STAGES-1:0]            stall;
   logic                         accept;
   logic                         sx;
   logic                         hi_sel;

   // Backpressure chain: a stage stalls only if it holds an op and everything
   // downstream of it is also blocked.
   always_comb begin
      logic run;
      stall = '0;
      run = v_q[Last] & ~out_ready;
      stall[Last] = run;
      for (int k = int'(STAGES) - 2; k >= 0; k--) begin
         run = v_q[k] & run;
         stall[k] = run;
      end
   end

   // Handshake, capture enables and operand extension (sign only for MULH).
   always_comb begin
      dp_en    = ~stall;
      in_ready = ~stall[0] & ~flush;
      accept   = in_valid & in_ready;
      sx       = (in_op == OpMulh);
      dp_a     = {sx & in_a[DATA_W-1], in_a};
      dp_b     = {sx & in_b[DATA_W-1], in_b};
   end

   // Stage tracking next-state: load stage 0 from the request, shift the rest.
   always_comb begin
      v_d    = v_q;
      op_d   = op_q;
      dest_d = dest_q;
      if (dp_en[0]) begin
         v_d[0]    = accept;
         op_d[0]   = in_op;
         dest_d[0] = in_dest;
      end
      for (int k = 1; k < int'(STAGES); k++) begin
         if (dp_en[k]) begin
            v_d[k]    = v_q[k-1];
            op_d[k]   = op_q[k-1];
            dest_d[k] = dest_q[k-1];
         end
      end
      if (flush) begin
         v_d = '0;
      end
   end

   // Result presentation; payload is zeroed whenever nothing is valid.
   always_comb begin
      out_valid  = v_q[Last];
      hi_sel     = (op_q[Last] == OpMulh) || (op_q[Last] == OpMulhu);
      out_result = '0;
      out_dest   = '0;
      if (out_valid) begin
         out_result = hi_sel ? dp_prod[2*DATA_W-1:DATA_W] : dp_prod[DATA_W-1:0];
         out_dest   = dest_q[Last];
      end
      busy = |v_q;
   end

   // Completion and stall counters, wrapping naturally.
   always_comb begin
      done_cnt_d  = done_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (out_valid && out_ready) begin
         done_cnt_d = done_cnt_q + 32'd1;
      end
      if (out_valid && !out_ready) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   assign done_cnt  = done_cnt_q;
   assign stall_cnt = stall_cnt_q;

   // State registers; reset drops all in-flight ops at once.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         v_q         <= '0;
         op_q        <= '0;
         dest_q      <= '0;
         done_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         v_q         <= v_d;
         op_q        <= op_d;
         dest_q      <= dest_d;
         done_cnt_q  <= done_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // OpMul is named for readability of the op map; low half is the default.
   logic unused_opmul;
   assign unused_opmul = ^OpMul;

endmodule

// File: tb/tb_mul_pipe_ctrl.sv
// Self-checking bench for mul_pipe_ctrl: a two-register multiply stands in for
// the datapath, and a queue-based reference model predicts every output.
module tb_mul_pipe_ctrl;

   localparam int DATA_W = 32;
   localparam int STAGES = 2;
   localparam int TAG_W  = 5;

   logic                clk;
   logic                resetn;
   logic                in_valid;
   logic                in_ready;
   logic [1:0]          in_op;
   logic [DATA_W-1:0]   in_a;
   logic [DATA_W-1:0]   in_b;
   logic [TAG_W-1:0]    in_dest;
   logic                flush;
   logic [DATA_W:0]     dp_a;
   logic [DATA_W:0]     dp_b;
   logic [STAGES-1:0]   dp_en;
   logic [2*DATA_W-1:0] dp_prod;
   logic                out_valid;
   logic                out_ready;
   logic [DATA_W-1:0]   out_result;
   logic [TAG_W-1:0]    out_dest;
   logic                busy;
   logic [31:0]         done_cnt;
   logic [31:0]         stall_cnt;

   mul_pipe_ctrl #(
      .DATA_W(DATA_W),
      .STAGES(STAGES),
      .TAG_W (TAG_W)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_dest   (in_dest),
      .flush     (flush),
      .dp_a      (dp_a),
      .dp_b      (dp_b),
      .dp_en     (dp_en),
      .dp_prod   (dp_prod),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_result(out_result),
      .out_dest  (out_dest),
      .busy      (busy),
      .done_cnt  (done_cnt),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Datapath stand-in: signed 33x33 multiply, two enabled register stages.
   logic signed [65:0]  prod_full;
   logic [63:0]         dp_s0, dp_s1;
   assign prod_full = $signed(dp_a) * $signed(dp_b);
   assign dp_prod   = dp_s1;
   initial begin
      dp_s0 = '0;
      dp_s1 = '0;
   end
   always @(posedge clk) begin
      if (dp_en[0]) dp_s0 <= prod_full[63:0];
      if (dp_en[1]) dp_s1 <= dp_s0;
   end

   // Reference model: queue of expected results in acceptance order.
   typedef struct {
      logic [31:0] res;
      logic [4:0]  dest;
      int          cyc;
   } exp_t;
   exp_t q[$];
   int   cyc;
   int   m_done;
   int   m_stall;
   int   n_acc;

   int   n_pass;
   int   n_total;

   logic [DATA_W:0]   last_dp_a;
   logic              last_in_ready;
   logic              last_out_valid;
   logic [31:0]       last_out_result;
   logic [4:0]        last_out_dest;
   logic              last_busy;
   logic [31:0]       last_done_cnt;
   logic [31:0]       last_stall_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      longint          sa, sb, ps;
      longint unsigned ua, ub, pu;
      sa = $signed(a);
      sb = $signed(b);
      ps = sa * sb;
      ua = a;
      ub = b;
      pu = ua * ub;
      case (op)
         2'b01:   return ps[63:32];
         2'b10:   return pu[63:32];
         default: return pu[31:0];
      endcase
   endfunction

   // One clock cycle: drive after the edge, check at the falling edge, then
   // advance the reference model by the upcoming rising edge.
   task automatic cycle(input logic iv, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] dest, input logic ordy,
                        input logic fl);
      logic exp_ir;
      logic exp_ov;
      exp_t e;
      @(posedge clk);
      #1;
      in_valid  = iv;
      in_op     = op;
      in_a      = a;
      in_b      = b;
      in_dest   = dest;
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
      exp_ir = !fl && !(q.size() == STAGES && !ordy);
      exp_ov = 1'b0;
      if (q.size() != 0) exp_ov = (cyc - q[0].cyc) >= STAGES;
      chk("in_ready", in_ready, exp_ir);
      chk("out_valid", out_valid, exp_ov);
      chk("busy", busy, q.size() != 0);
      chk("done_cnt", done_cnt, m_done);
      chk("stall_cnt", stall_cnt, m_stall);
      chk("dp_a", dp_a, {(op == 2'b01) & a[31], a});
      chk("dp_b", dp_b, {(op == 2'b01) & b[31], b});
      if (exp_ov) begin
         chk("out_result", out_result, q[0].res);
         chk("out_dest", out_dest, q[0].dest);
      end else begin
         chk("out_result_idle", out_result, 0);
         chk("out_dest_idle", out_dest, 0);
      end
      last_dp_a       = dp_a;
      last_in_ready   = in_ready;
      last_out_valid  = out_valid;
      last_out_result = out_result;
      last_out_dest   = out_dest;
      last_busy       = busy;
      last_done_cnt   = done_cnt;
      last_stall_cnt  = stall_cnt;
      if (exp_ov && ordy) begin
         void'(q.pop_front());
         m_done++;
      end
      if (exp_ov && !ordy) m_stall++;
      if (fl) begin
         q.delete();
      end else if (iv && exp_ir) begin
         e.res  = ref_result(op, a, b);
         e.dest = dest;
         e.cyc  = cyc;
         q.push_back(e);
         n_acc++;
      end
      cyc++;
   endtask

   task automatic idle();
      cycle(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0);
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        sx;
   } vec_t;
   vec_t vecs[6];

   initial begin
      logic [31:0] base_done;
      logic [31:0] base_stall;
      int          budget;
      logic        iv, ordy, fl;
      logic [1:0]  op;
      logic [31:0] a, b;

      vecs[0] = '{op: 2'b00, a: 32'd3,          b: 32'd5,          res: 32'd15,        sx: 1'b0};
      vecs[1] = '{op: 2'b01, a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  res: 32'h0,         sx: 1'b1};
      vecs[2] = '{op: 2'b10, a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  res: 32'hFFFF_FFFE, sx: 1'b0};
      vecs[3] = '{op: 2'b01, a: 32'h8000_0000,  b: 32'd2,          res: 32'hFFFF_FFFF, sx: 1'b1};
      vecs[4] = '{op: 2'b10, a: 32'h8000_0000,  b: 32'd2,          res: 32'h1,         sx: 1'b0};
      vecs[5] = '{op: 2'b11, a: 32'hFFFF_FFFF,  b: 32'd2,          res: 32'hFFFF_FFFE, sx: 1'b0};

      n_pass = 0; n_total = 0; cyc = 0; m_done = 0; m_stall = 0; n_acc = 0;
      resetn = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0;
      in_dest = '0; flush = 1'b0; out_ready = 1'b1;

      // Reset state
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_result", out_result, 0);
      chk("rst_out_dest", out_dest, 0);
      chk("rst_done_cnt", done_cnt, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      @(posedge clk);
      @(posedge clk);
      #5 resetn = 1'b1;

      // Single ops: latency, operand extension, half selection, completion count
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), 1'b1, 1'b0);
         chk("vec_accept", last_in_ready, 1);
         chk("vec_sx", last_dp_a[32], vecs[i].sx);
         idle();
         chk("vec_lat1", last_out_valid, 0);
         idle();
         chk("vec_valid", last_out_valid, 1);
         chk("vec_result", last_out_result, vecs[i].res);
         chk("vec_dest", last_out_dest, 5'(i + 1));
         idle();
         chk("vec_done", last_done_cnt, i + 1);
      end

      // Back-to-back with backpressure: third op held until space frees
      cycle(1'b1, 2'b00, 32'd10, 32'd2, 5'd1, 1'b0, 1'b0);
      base_done  = last_done_cnt;
      base_stall = last_stall_cnt;
      chk("b2b_acc1", last_in_ready, 1);
      cycle(1'b1, 2'b00, 32'd20, 32'd3, 5'd2, 1'b0, 1'b0);
      chk("b2b_acc2", last_in_ready, 1);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 2'b00, 32'd30, 32'd4, 5'd3, 1'b0, 1'b0);
         chk("b2b_full", last_in_ready, 0);
         chk("b2b_hold_dest", last_out_dest, 1);
      end
      cycle(1'b1, 2'b00, 32'd30, 32'd4, 5'd3, 1'b1, 1'b0);
      chk("b2b_acc3", last_in_ready, 1);
      chk("b2b_out1", last_out_dest, 1);
      chk("b2b_res1", last_out_result, 20);
      idle();
      chk("b2b_out2", last_out_dest, 2);
      chk("b2b_res2", last_out_result, 60);
      idle();
      chk("b2b_out3", last_out_dest, 3);
      chk("b2b_res3", last_out_result, 120);
      idle();
      chk("b2b_done", last_done_cnt - base_done, 3);
      chk("b2b_stall", last_stall_cnt - base_stall, 4);
      chk("b2b_idle", last_busy, 0);

      // Flush with two ops in flight and a request in the flush cycle
      cycle(1'b1, 2'b00, 32'd4, 32'd4, 5'd4, 1'b0, 1'b0);
      cycle(1'b1, 2'b00, 32'd5, 32'd5, 5'd5, 1'b0, 1'b0);
      cycle(1'b1, 2'b00, 32'd6, 32'd6, 5'd6, 1'b0, 1'b1);
      chk("flush_no_accept", last_in_ready, 0);
      chk("flush_busy_before", last_busy, 1);
      base_done = last_done_cnt;
      idle();
      chk("flush_busy", last_busy, 0);
      chk("flush_out_valid", last_out_valid, 0);
      idle();
      chk("flush_no_result", last_out_valid, 0);
      chk("flush_done", last_done_cnt, base_done);

      // Asynchronous reset mid-cycle with ops in flight
      cycle(1'b1, 2'b00, 32'd8, 32'd8, 5'd7, 1'b0, 1'b0);
      cycle(1'b1, 2'b00, 32'd9, 32'd9, 5'd8, 1'b0, 1'b0);
      @(posedge clk);
      #3;
      chk("pre_rst_valid", out_valid, 1);
      resetn = 1'b0; in_valid = 1'b0; flush = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done_cnt, 0);
      chk("arst_stall", stall_cnt, 0);
      q.delete(); m_done = 0; m_stall = 0;
      @(posedge clk);
      #5 resetn = 1'b1;
      cycle(1'b1, 2'b00, 32'd7, 32'd6, 5'd9, 1'b1, 1'b0);
      idle();
      chk("arst_lat", last_out_valid, 0);
      idle();
      chk("arst_valid", last_out_valid, 1);
      chk("arst_result", last_out_result, 42);

      // Random stress against the reference model
      n_acc  = 0;
      budget = 0;
      while (n_acc < 1000 && budget < 20000) begin
         iv   = ($urandom_range(0, 99) < 70);
         ordy = ($urandom_range(0, 99) < 70);
         fl   = ($urandom_range(0, 99) < 2);
         op   = 2'($urandom_range(0, 3));
         a    = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
         b    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
         cycle(iv, op, a, b, 5'($urandom_range(0, 31)), ordy, fl);
         budget++;
      end
      chk("stress_accepted", n_acc, 1000);
      for (int i = 0; i < 4; i++) idle();
      chk("stress_drained", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mul_pipe_ctrl.md
Name: mul_pipe_ctrl

Overview:
Sequencing controller for the pipelined Booth/Wallace multiplier datapath used by the EXE stage. It accepts multiply requests over a valid/ready handshake and drives sign-extended operands and per-stage advance enables into the datapath. It tracks op type and destination tag for each in-flight stage, applies backpressure, and selects the low or high product half on return. It also supports pipeline flush on exception/branch cancel and keeps completion and stall counters.

Parameters:
DATA_W, 32, operand width
STAGES, 2, number of datapath register stages (fixed datapath latency)
TAG_W, 5, destination tag width

Ports:
clk  input  1  clock
resetn  input  1  reset; asynchronous, active-low
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid & in_ready
in_op  input  2  00 MUL (low), 01 MULH (signed high), 10 MULHU (unsigned high), 11 reserved
in_a  input  DATA_W  operand A
in_b  input  DATA_W  operand B
in_dest  input  TAG_W  destination tag
flush  input  1  cancel all in-flight ops
dp_a  output  DATA_W+1  extended operand A to datapath
dp_b  output  DATA_W+1  extended operand B to datapath
dp_en  output  STAGES  dp_en[k] = datapath stage-k register capture enable
dp_prod  input  2*DATA_W  registered product from final datapath stage
out_valid  output  1  result valid
out_ready  input  1  consumer ready
out_result  output  DATA_W  selected product half
out_dest  output  TAG_W  tag of presented result
busy  output  1  any stage valid
done_cnt  output  32  completed ops (output handshakes)
stall_cnt  output  32  cycles with out_valid & !out_ready

Behaviour:
- State: per-stage v[k], op[k], dest[k] for k = 0..STAGES-1.
- Reset (async, resetn=0): all v=0, done_cnt=0, stall_cnt=0. Outputs read out_valid=0, busy=0, out_result=0, out_dest=0. Asserting reset mid-operation drops in-flight ops immediately.
- Stall chain (combinational):
  - stall[STAGES-1] = v[STAGES-1] & !out_ready
  - stall[k] = v[k] & stall[k+1]
- dp_en[k] = !stall[k].
- in_ready = !stall[0] & !flush. in_ready depends combinationally on out_ready; this is intentional.
- Accept (in_valid & in_ready): v[0]<=1, op[0]<=in_op, dest[0]<=in_dest. If dp_en[0] & !accept, v[0]<=0.
- Advance for k>0: when dp_en[k], stage k loads v/op/dest from stage k-1.
- Throughput: 1 op/cycle with no backpressure.
- Latency: a request accepted in cycle N gives out_valid in cycle N+STAGES, with that cycle's dp_prod.
- Order is strictly preserved. No op is dropped or duplicated under any out_ready pattern.
- Operand extension:
  - dp_a = {sx & in_a[DATA_W-1], in_a}, where sx = (in_op==01).
  - dp_b is extended the same way.
  - MUL, MULHU and reserved ops use zero extension.
- Result: out_valid = v[STAGES-1].
  - op MUL or reserved: out_result = dp_prod[DATA_W-1:0].
  - op MULH or MULHU: out_result = dp_prod[2*DATA_W-1:DATA_W].
  - out_result and out_dest are forced to 0 when out_valid=0.
- Flush:
  - Next edge clears all v bits, so busy=0 and out_valid=0 the following cycle.
  - A request presented in the flush cycle is not accepted.
  - An output handshake in the flush cycle still completes and counts in done_cnt.
- Counters: done_cnt += 1 on out_valid & out_ready; stall_cnt += 1 on out_valid & !out_ready. Both wrap modulo 2^32.
- busy = OR of all v.

Test Plan:
- MUL in_a=3, in_b=5, out_ready=1, accepted in cycle 0 → out_valid in cycle 2, out_result=15, out_dest=in_dest; done_cnt=1. Bench models the datapath as a 2-stage register multiply on dp_a*dp_b.
- MULH a=0xFFFFFFFF, b=0xFFFFFFFF → result 0x00000000. MULHU same operands → 0xFFFFFFFE. MULH a=0x80000000, b=2 → 0xFFFFFFFF; check dp_a[32]=1 for MULH and 0 for MULHU.
- Back-to-back ops with out_ready:
  - Three ops tags 1,2,3 on consecutive cycles, out_ready=0 for 4 cycles → in_ready drops once both stages are full.
  - Third op is held until space frees; results then emerge in order 1,2,3.
  - stall_cnt=4, done_cnt=3.
- Flush with 2 ops in flight and in_valid=1 in the flush cycle → in_ready=0 that cycle; next cycle busy=0, out_valid=0; no results emerge; done_cnt unchanged.
- resetn pulsed low asynchronously mid-cycle with ops in flight → out_valid, busy and counters go to 0 immediately. After release, a new MUL 7*6 returns 42 after 2 cycles.
- Random stress: 1000 random ops, ops, out_ready patterns and 2% flush rate vs. scoreboard → every non-flushed op completes exactly once, in order, with correct half.
